// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; optional MULDIV_FAST_MUL_EN
module ex_muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] srcA,
  input  logic [DATA_W-1:0] srcB,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [DATA_W-1:0]   oper_q, oper_d;   // multiplicand or divisor magnitude
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;     // product/quotient must be negated
  logic                rem_neg_q, rem_neg_d;
  logic                div0_q, div0_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic                op_signed, op_is_mul, op_is_div;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [DATA_W-1:0]   addend;
  logic [DATA_W:0]     add_sum;
  logic [DATA_W:0]     rem_shift;
  logic [DATA_W+1:0]   rem_diff;
  logic                rem_fits;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign op_is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign abs_a     = (op_signed && srcA[DATA_W-1]) ? -srcA : srcA;
  assign abs_b     = (op_signed && srcB[DATA_W-1]) ? -srcB : srcB;

  // Shift-add step: add multiplicand to the upper half when the current multiplier bit is set.
  assign addend  = acc_q[0] ? oper_q : '0;
  assign add_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, addend};

  // Restoring step: shift the next dividend bit into the remainder and trial-subtract.
  assign rem_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
  assign rem_diff  = {1'b0, rem_shift} - {2'b00, oper_q};
  assign rem_fits  = ~rem_diff[DATA_W+1];

  // Magnitudes back to two's complement; divide-by-zero leaves the dividend as remainder.
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

  // Next-state and datapath update for IDLE/CALC/FIX.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    oper_d    = oper_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          if (op == OP_MTHI) begin
            hi_d = srcA;
          end else if (op == OP_MTLO) begin
            lo_d = srcA;
          end else if (op_is_mul || op_is_div) begin
            is_div_d  = op_is_div;
            neg_d     = op_signed && (srcA[DATA_W-1] ^ srcB[DATA_W-1]);
            rem_neg_d = op_signed && srcA[DATA_W-1];
            div0_d    = op_is_div && (srcB == '0);
            cnt_d     = '0;
            state_d   = ST_CALC;
            if (op_is_div) begin
              acc_d  = {{DATA_W{1'b0}}, abs_a};
              oper_d = abs_b;
            end else begin
              acc_d  = {{DATA_W{1'b0}}, abs_b};
              oper_d = abs_a;
`ifdef MULDIV_FAST_MUL_EN
              acc_d   = {{DATA_W{1'b0}}, abs_a} * {{DATA_W{1'b0}}, abs_b};
              state_d = ST_FIX;
`endif
            end
          end
        end
      end

      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = {(rem_fits ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0]),
                     acc_q[DATA_W-2:0], rem_fits};
          end else begin
            acc_d = {add_sum, acc_q[DATA_W-1:1]};
          end
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = div0_q ? '1 : quo_fix;
            hi_d = rem_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and architectural registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      oper_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      oper_q    <= oper_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srcA, srcB;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_pass  = 0;
  int n_total = 0;

  ex_muldiv_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          q, r;
    case (o)
      3'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; return up; end
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {32'(r), 32'(q)};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Cycle-level model: an accepted op completes a fixed number of edges later unless flushed.
  int          m_left;
  logic        m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; m_res <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        if (flush) m_left <= 0;
        else if (m_left == 1) begin
          m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; m_done <= 1'b1; m_left <= 0;
        end else m_left <= m_left - 1;
      end else if (start && !flush) begin
        if (op == 3'd4) m_hi <= srcA;
        else if (op == 3'd5) m_lo <= srcA;
        else if (op <= 3'd3) begin
          m_res  <= model_result(op, srcA, srcB);
          m_left <= (op <= 3'd1) ? MUL_LAT : DIV_LAT;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {31'd0, busy}, {31'd0, m_left != 0});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int flush_at, input int glitch_at, output int nbusy, output int ndone);
    nbusy = 0; ndone = 0;
    @(negedge clk); start = 1'b1; op = o; srcA = a; srcB = b;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 36; i++) begin
      if (busy) nbusy++;
      if (done) ndone++;
      flush = (i == flush_at);
      if (i == glitch_at) begin start = 1'b1; op = 3'd3; srcA = 32'd5; srcB = 32'd0; end
      else start = 1'b0;
      @(negedge clk);
    end
    flush = 1'b0; start = 1'b0;
  endtask

  int nb, nd;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; srcA = '0; srcB = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    do_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, -1, -1, nb, nd);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("mult_busy_cycles", nb, MUL_LAT);
    chk("mult_done_pulses", nd, 1);

    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, (MUL_LAT > 5) ? 5 : -1, nb, nd);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    chk("multu_done_pulses", nd, 1);

    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1, 7, nb, nd);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_busy_cycles", nb, DIV_LAT);

    do_op(3'd3, 32'd7, 32'd0, -1, -1, nb, nd);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'd7);
    chk("divu0_busy_cycles", nb, DIV_LAT);

    do_op(3'd2, 32'hFFFF_FFF9, 32'd0, -1, -1, nb, nd);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'hFFFF_FFF9);

    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, nb, nd);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    do_op(3'd3, 32'd100, 32'd7, -1, -1, nb, nd);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    do_op(3'd4, 32'h1234_5678, 32'd0, -1, -1, nb, nd);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy_cycles", nb, 0);
    chk("mthi_done_pulses", nd, 0);
    do_op(3'd5, 32'h9ABC_DEF0, 32'd0, -1, -1, nb, nd);
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi", hi, 32'h1234_5678);

    do_op(3'd3, 32'd100, 32'd7, 10, -1, nb, nd);
    chk("flush_busy_cycles", nb, 11);
    chk("flush_done_pulses", nd, 0);
    chk("flush_hi", hi, 32'h1234_5678);
    chk("flush_lo", lo, 32'h9ABC_DEF0);

    @(negedge clk); start = 1'b1; flush = 1'b1; op = 3'd5; srcA = 32'hCAFE_F00D;
    @(negedge clk); op = 3'd3; srcA = 32'd9; srcB = 32'd2;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    chk("startflush_busy", {31'd0, busy}, 32'd0);
    chk("startflush_lo", lo, 32'h9ABC_DEF0);

    do_op(3'd6, 32'hDEAD_BEEF, 32'd1, -1, -1, nb, nd);
    chk("undef_busy_cycles", nb, 0);
    chk("undef_hi", hi, 32'h1234_5678);
    chk("undef_lo", lo, 32'h9ABC_DEF0);

    @(negedge clk); start = 1'b1; op = 3'd3; srcA = 32'd1000; srcB = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(3'd0, 32'd3, 32'd5, -1, -1, nb, nd);
    chk("mul35_lo", lo, 32'd15);
    chk("mul35_hi", hi, 32'd0);
    chk("mul35_busy_cycles", nb, MUL_LAT);
    chk("mul35_done_pulses", nd, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
